// File: rtl/bool_scan_pkg.sv
// Shared definitions for the truth-table scanner: FSM encoding and default sizing.
package bool_scan_pkg;

  localparam int DEF_N_IN          = 5;
  localparam int DEF_SETTLE_CYCLES = 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] SAMPLE = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = IDLE,
    ST_SETTLE = SETTLE,
    ST_SAMPLE = SAMPLE,
    ST_DONE   = DONE
  } state_t;

endpackage

// File: rtl/bool_scan_settle_timer.sv
// Loadable down-counter with a zero flag; times how long each vector is held.
module bool_scan_settle_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/bool_truth_table_scanner.sv
// Walks every input vector of a combinational function, samples F and builds its truth table.
// Optional expected-table compare is enabled by defining EXPECT_CHECK_EN.
module bool_truth_table_scanner
  import bool_scan_pkg::*;
#(
  parameter int N_IN          = DEF_N_IN,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  output logic [N_IN-1:0]      vec_out,
  input  logic                 f_in,
  output logic                 busy,
  output logic                 done,
  output logic [2**N_IN-1:0]   truth_table,
  output logic [N_IN:0]        ones_count
`ifdef EXPECT_CHECK_EN
  ,
  input  logic [2**N_IN-1:0]   expected,
  output logic                 mismatch,
  output logic [N_IN-1:0]      mismatch_idx
`endif
);

  localparam int              TW       = $clog2(SETTLE_CYCLES + 1);
  localparam logic [TW-1:0]   RELOAD   = TW'(SETTLE_CYCLES - 1);
  localparam logic [N_IN-1:0] LAST_IDX = '1;

  state_t state, state_next;
  logic   timer_load, timer_dec, timer_zero;
  logic   launch, capture;

  assign launch  = (state == ST_IDLE) && start && !abort;
  assign capture = (state == ST_SAMPLE) && !abort;

  bool_scan_settle_timer #(.W(TW)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (timer_load),
    .load_value (RELOAD),
    .dec        (timer_dec),
    .zero       (timer_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    timer_load = 1'b0;
    timer_dec  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (launch) begin
          state_next = ST_SETTLE;
          timer_load = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (abort)           state_next = ST_IDLE;
        else if (timer_zero) state_next = ST_SAMPLE;
        else                 timer_dec  = 1'b1;
      end
      ST_SAMPLE: begin
        if (abort) begin
          state_next = ST_IDLE;
        end else if (vec_out == LAST_IDX) begin
          state_next = ST_DONE;
        end else begin
          state_next = ST_SETTLE;
          timer_load = 1'b1;
        end
      end
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // vec_out doubles as the scan index; it stops at the last vector and only a new start rewinds it.
  // NOTE: the result table is an ordinary flop vector, so it is cleared by rst like any other state.
  always_ff @(posedge clk) begin
    if (rst) begin
      vec_out     <= '0;
      truth_table <= '0;
      ones_count  <= '0;
    end else if (launch) begin
      vec_out     <= '0;
      truth_table <= '0;
      ones_count  <= '0;
    end else if (capture) begin
      truth_table[vec_out] <= f_in;
      ones_count           <= ones_count + (N_IN + 1)'(f_in);
      if (vec_out != LAST_IDX) vec_out <= vec_out + N_IN'(1);
    end
  end

  assign busy = (state == ST_SETTLE) || (state == ST_SAMPLE);
  assign done = (state == ST_DONE);

`ifdef EXPECT_CHECK_EN
  logic [2**N_IN-1:0] expected_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      expected_q   <= '0;
      mismatch     <= 1'b0;
      mismatch_idx <= '0;
    end else if (launch) begin
      expected_q   <= expected;
      mismatch     <= 1'b0;
      mismatch_idx <= '0;
    end else if (capture && !mismatch && (f_in != expected_q[vec_out])) begin
      mismatch     <= 1'b1;
      mismatch_idx <= vec_out;
    end
  end
`endif

endmodule

// File: tb/tb_bool_truth_table_scanner.sv
// Scoreboard bench for bool_truth_table_scanner: stimulus queues expected scans, a monitor checks them.
module tb_bool_truth_table_scanner;

  localparam int N_IN   = 5;
  localparam int SETTLE = 1;
  localparam int TBL    = 2 ** N_IN;
  localparam int LAT    = 1 + TBL * (SETTLE + 1);

  logic              clk = 1'b0;
  logic              rst, start, abort;
  logic [N_IN-1:0]   vec_out;
  logic              f_in;
  logic              busy, done;
  logic [TBL-1:0]    truth_table;
  logic [N_IN:0]     ones_count;
  logic [TBL-1:0]    func_tbl;
`ifdef EXPECT_CHECK_EN
  logic [TBL-1:0]    expected;
  logic              mismatch;
  logic [N_IN-1:0]   mismatch_idx;
`endif

  // Datapath model: F is a lookup in the table currently under test.
  assign f_in = func_tbl[vec_out];

  bool_truth_table_scanner #(.N_IN(N_IN), .SETTLE_CYCLES(SETTLE)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .vec_out      (vec_out),
    .f_in         (f_in),
    .busy         (busy),
    .done         (done),
    .truth_table  (truth_table),
    .ones_count   (ones_count)
`ifdef EXPECT_CHECK_EN
    ,
    .expected     (expected),
    .mismatch     (mismatch),
    .mismatch_idx (mismatch_idx)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [TBL-1:0] tbl;
    int             start_cyc;
  } scan_t;
  scan_t sb_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int spurious_done = 0;
  int sweep_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [TBL-1:0] model_tbl();
    logic [TBL-1:0] t;
    for (int i = 0; i < TBL; i++) t[i] = ((i >> 4) & 1) & (i & 1);
    return t;
  endfunction

  // Monitor: checks the vector sweep during a scan and the result when done pulses.
  always @(negedge clk) begin : monitor
    int    j;
    scan_t e;
    if (!rst) begin
      if (sb_q.size() > 0 && busy) begin
        j = cyc - sb_q[0].start_cyc;
        if (j == 1) sweep_err = 0;
        if (vec_out !== N_IN'((j - 1) / 2)) sweep_err++;
      end
      if (done) begin
        if (sb_q.size() == 0) begin
          spurious_done++;
        end else begin
          e = sb_q.pop_front();
          check("done_cycle", cyc, e.start_cyc + LAT);
          check("truth_table", truth_table, e.tbl);
          check("ones_count", ones_count, $countones(e.tbl));
          check("vec_sweep_errors", sweep_err, 0);
          check("busy_during_done", busy, 0);
        end
      end
    end
  end

  task automatic begin_scan(input logic [TBL-1:0] tbl, input logic hold);
    scan_t e;
    @(negedge clk);
    func_tbl = tbl;
    start = 1'b1;
    e.tbl = tbl;
    e.start_cyc = cyc;
    sb_q.push_back(e);
    @(negedge clk);
    if (!hold) start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("done_timeout", done, 1);
  endtask

  task automatic check_idle_after();
    @(negedge clk);
    check("busy_after_done", busy, 0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [TBL-1:0] r;
    logic [TBL-1:0] part;
    int             n_sampled;
    rst = 1'b1; start = 1'b0; abort = 1'b0; func_tbl = '0;
`ifdef EXPECT_CHECK_EN
    expected = '0;
`endif
    repeat (2) @(negedge clk);
    check("rst_vec_out", vec_out, 0);
    check("rst_truth_table", truth_table, 0);
    check("rst_ones_count", ones_count, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
`ifdef EXPECT_CHECK_EN
    check("rst_mismatch", mismatch, 0);
`endif
    rst = 1'b0;

    // Reference function V & Z.
    begin_scan(model_tbl(), 1'b0);
    check("busy_after_start", busy, 1);
    wait_done();
    check("model_table_const", truth_table, 32'hAAAA_0000);
    check("model_ones_const", ones_count, 8);
    check_idle_after();
    check("vec_out_holds_last", vec_out, TBL - 1);

    // Random functions, including the all-zero and all-one edges.
    for (int s = 0; s < 6; s++) begin
      r = (s == 0) ? '0 : (s == 1) ? '1 : TBL'($urandom());
      begin_scan(r, 1'b0);
      wait_done();
      check_idle_after();
    end

    // Abort on the 20th cycle after start: partial results stay, no done.
    r = TBL'($urandom()) | TBL'(1);
    begin_scan(r, 1'b0);
    repeat (19) @(negedge clk);
    abort = 1'b1;
    void'(sb_q.pop_back());
    @(negedge clk);
    abort = 1'b0;
    n_sampled = (20 - 1) / 2;
    part = r & ((TBL'(1) << n_sampled) - TBL'(1));
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_partial_table", truth_table, part);
    check("abort_partial_ones", ones_count, $countones(part));
    repeat (70) @(negedge clk);
    check("abort_stays_idle", busy, 0);

    // Abort and start together in IDLE: nothing starts.
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("abort_beats_start", busy, 0);
    check("abort_beats_start_tbl", truth_table, part);

    begin_scan(model_tbl(), 1'b0);
    wait_done();
    check("restart_table_const", truth_table, 32'hAAAA_0000);
    check_idle_after();

    // Start held high through the whole scan and the DONE cycle.
    begin_scan(TBL'($urandom()), 1'b1);
    wait_done();
    @(negedge clk);
    start = 1'b0;
    check("no_rearm_from_done", busy, 0);
    @(negedge clk);
    check("no_rearm_from_done_2", busy, 0);

    // Reset at cycle 30 of a scan wipes everything.
    begin_scan('1, 1'b0);
    repeat (29) @(negedge clk);
    rst = 1'b1;
    void'(sb_q.pop_back());
    @(negedge clk);
    check("midrst_vec_out", vec_out, 0);
    check("midrst_truth_table", truth_table, 0);
    check("midrst_ones_count", ones_count, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    rst = 1'b0;
    repeat (70) @(negedge clk);
    check("midrst_stays_idle", busy, 0);

`ifdef EXPECT_CHECK_EN
    expected = 32'hAAAA_0001;
    begin_scan(model_tbl(), 1'b0);
    wait_done();
    check("mismatch_flag", mismatch, 1);
    check("mismatch_idx", mismatch_idx, 0);
    check_idle_after();
    expected = model_tbl();
    begin_scan(model_tbl(), 1'b0);
    wait_done();
    check("mismatch_clear", mismatch, 0);
    check_idle_after();
`endif

    repeat (3) @(negedge clk);
    check("spurious_done", spurious_done, 0);
    check("scoreboard_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
